// File: rtl/mem_access_pkg.sv
// bexkat1Def: shared definitions for the memory-access pipeline stage.
//   mem_op_t   : memory operation code carried with each instruction
//   mem_size_t : access width
//   state_t    : FSM state of mem_access (kept as plain localparams so
//                older code that compares raw state bits keeps working)
//   is_misaligned() : true when an access straddles its natural alignment
package bexkat1Def;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2,
    MEM_RSVD  = 2'd3
  } mem_op_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } mem_size_t;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t BUS  = 2'd1;
  localparam state_t HOLD = 2'd2;

  // The unused size encoding behaves like a word everywhere in this stage.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis_s;
    case (mem_size_t'(size))
      SIZE_BYTE: mis_s = 1'b0;
      SIZE_HALF: mis_s = addr_lo[0];
      default:   mis_s = (addr_lo != 2'b00);
    endcase
    return mis_s;
  endfunction

endpackage

// File: rtl/mem_lane.sv
// mem_lane: purely combinational byte-lane steering for a big-endian
// 32-bit bus (lane 3 = bits 31:24 = byte offset 0).
//   size        in  2   access width (mem_size_t encoding)
//   addr_lo     in  2   low effective-address bits
//   store_data  in  32  right-aligned store value
//   read_data   in  32  raw bus read data
//   sel         out 4   byte-lane enables
//   write_data  out 32  store value replicated across lanes
//   load_data   out 32  selected lanes, zero-extended
// Half accesses only look at addr_lo[1]; words ignore addr_lo entirely.
module mem_lane
  import bexkat1Def::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] read_data,
  output logic [3:0]  sel,
  output logic [31:0] write_data,
  output logic [31:0] load_data
);

  // Lane select, store replication and load extraction per access width.
  always_comb begin
    sel        = 4'b1111;
    write_data = store_data;
    load_data  = read_data;
    case (mem_size_t'(size))
      SIZE_BYTE: begin
        write_data = {4{store_data[7:0]}};
        case (addr_lo)
          2'd0:    begin sel = 4'b1000; load_data = {24'd0, read_data[31:24]}; end
          2'd1:    begin sel = 4'b0100; load_data = {24'd0, read_data[23:16]}; end
          2'd2:    begin sel = 4'b0010; load_data = {24'd0, read_data[15:8]};  end
          default: begin sel = 4'b0001; load_data = {24'd0, read_data[7:0]};   end
        endcase
      end
      SIZE_HALF: begin
        write_data = {2{store_data[15:0]}};
        if (addr_lo[1]) begin
          sel       = 4'b0011;
          load_data = {16'd0, read_data[15:0]};
        end else begin
          sel       = 4'b1100;
          load_data = {16'd0, read_data[31:16]};
        end
      end
      default: begin
        sel        = 4'b1111;
        write_data = store_data;
        load_data  = read_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage of the bexkat1 pipeline. Non-memory instructions
// flow through with one cycle of latency; loads/stores run one single-beat
// bus transfer while stalling the execute stage.
//   clk_i, rst_i (async, active-high)
//   stall_i / stall_o        : stall from write-back / stall to execute
//   halt, reg_write, bank, ir: passed through with the instruction
//   alu_i, store_i           : effective address / right-aligned store data
//   mem_op_i, mem_size_i     : operation and width (bexkat1Def encodings)
//   sp_data_o                : loaded data or alu_i
//   bus_*                    : single-cycle-ack bus master
//   exc_o                    : misaligned-access exception, only present when
//                              BEXKAT1_MISALIGN_EXC_EN is defined
module mem_access
  import bexkat1Def::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  output logic        stall_o,
  input  logic        halt_i,
  output logic        halt_o,
  input  logic [1:0]  reg_write_i,
  output logic [1:0]  reg_write_o,
  input  logic [3:0]  bank_i,
  output logic [3:0]  bank_o,
  input  logic [63:0] ir_i,
  output logic [63:0] ir_o,
  input  logic [31:0] alu_i,
  input  logic [31:0] store_i,
  input  logic [1:0]  mem_op_i,
  input  logic [1:0]  mem_size_i,
  output logic [31:0] sp_data_o,
`ifdef BEXKAT1_MISALIGN_EXC_EN
  output logic        exc_o,
`endif
  output logic        bus_cyc_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i
);

  state_t      state_r, state_nxt_s;
  logic [31:0] buf_r;
  logic [31:0] load_data_s, result_s;
  logic        is_mem_s, is_store_s, misalign_s, start_s, exc_req_s;

  // Upstream holds its outputs while stall_o is high, so the request
  // inputs stay stable for the whole transfer and drive the bus directly.
  assign is_store_s = (mem_op_t'(mem_op_i) == MEM_STORE);
  assign is_mem_s   = is_store_s || (mem_op_t'(mem_op_i) == MEM_LOAD);
`ifdef BEXKAT1_MISALIGN_EXC_EN
  assign misalign_s = is_misaligned(mem_size_i, alu_i[1:0]);
`else
  assign misalign_s = 1'b0;
`endif
  assign start_s   = (state_r == IDLE) && is_mem_s && !stall_i && !misalign_s;
  assign exc_req_s = (state_r == IDLE) && is_mem_s && !stall_i && misalign_s;
  assign result_s  = is_store_s ? alu_i : load_data_s;

  // Reset gates the cycle strobe so an in-flight transfer is abandoned at once.
  assign bus_cyc_o = !rst_i && (start_s || (state_r == BUS));
  assign bus_we_o  = bus_cyc_o && is_store_s;
  assign bus_adr_o = {alu_i[31:2], 2'b00};

  mem_lane u_lane (
    .size       (mem_size_i),
    .addr_lo    (alu_i[1:0]),
    .store_data (store_i),
    .read_data  (bus_dat_i),
    .sel        (bus_sel_o),
    .write_data (bus_dat_o),
    .load_data  (load_data_s)
  );

  // Stall towards execute. stall_o drops on the edge where the result is
  // loaded (ack in BUS, or stall_i release in HOLD) so upstream advances in
  // the same edge and the instruction is not re-issued from IDLE.
  always_comb begin
    stall_o = 1'b1;
    case (state_r)
      IDLE: begin
        if (start_s) stall_o = 1'b1;
        else         stall_o = stall_i;
      end
      BUS: begin
        if (bus_ack_i && !stall_i) stall_o = 1'b0;
        else                       stall_o = 1'b1;
      end
      HOLD:    stall_o = stall_i;
      default: stall_o = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (start_s) state_nxt_s = BUS;
        else         state_nxt_s = IDLE;
      end
      BUS: begin
        if (bus_ack_i) state_nxt_s = stall_i ? HOLD : IDLE;
        else           state_nxt_s = BUS;
      end
      HOLD: begin
        if (!stall_i) state_nxt_s = IDLE;
        else          state_nxt_s = HOLD;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Result buffer: holds an acked result while write-back is stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                       buf_r <= 32'd0;
    else if (state_r == BUS && bus_ack_i && stall_i) buf_r <= result_s;
  end

  // Output register: pass-through, bubble, or memory result; holds on stall_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sp_data_o   <= 32'd0;
      reg_write_o <= 2'd0;
      halt_o      <= 1'b0;
      bank_o      <= 4'd0;
      ir_o        <= 64'd0;
    end else if (!stall_i) begin
      case (state_r)
        IDLE: begin
          if (start_s || exc_req_s) begin
            reg_write_o <= 2'd0;
            halt_o      <= 1'b0;
            ir_o        <= 64'd0;
          end else begin
            sp_data_o   <= alu_i;
            reg_write_o <= reg_write_i;
            halt_o      <= halt_i;
            bank_o      <= bank_i;
            ir_o        <= ir_i;
          end
        end
        BUS: begin
          if (bus_ack_i) begin
            sp_data_o   <= result_s;
            reg_write_o <= reg_write_i;
            halt_o      <= halt_i;
            bank_o      <= bank_i;
            ir_o        <= ir_i;
          end else begin
            reg_write_o <= 2'd0;
            halt_o      <= 1'b0;
            ir_o        <= 64'd0;
          end
        end
        HOLD: begin
          sp_data_o   <= buf_r;
          reg_write_o <= reg_write_i;
          halt_o      <= halt_i;
          bank_o      <= bank_i;
          ir_o        <= ir_i;
        end
        default: begin
          reg_write_o <= 2'd0;
          halt_o      <= 1'b0;
          ir_o        <= 64'd0;
        end
      endcase
    end
  end

`ifdef BEXKAT1_MISALIGN_EXC_EN
  logic exc_r;

  // Exception flag travels with the bubble that replaces the faulting access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         exc_r <= 1'b0;
    else if (!stall_i) exc_r <= exc_req_s;
  end

  assign exc_o = exc_r;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Randomised scoreboard bench for mem_access. The driver issues one
// instruction at a time, plays the bus slave, and pushes the expected
// write-back record; a monitor pops a record whenever a new instruction
// word appears on ir_o. Define BEXKAT1_MISALIGN_EXC_EN to cover exc_o.
module tb_mem_access;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0, stall_o;
  logic        halt_i = 1'b0, halt_o;
  logic [1:0]  reg_write_i = 2'd0, reg_write_o;
  logic [3:0]  bank_i = 4'd0, bank_o;
  logic [63:0] ir_i = 64'd0, ir_o;
  logic [31:0] alu_i = 32'd0, store_i = 32'd0, sp_data_o;
  logic [1:0]  mem_op_i = 2'd0, mem_size_i = 2'd0;
  logic        bus_cyc_o, bus_we_o;
  logic [31:0] bus_adr_o, bus_dat_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_i = 32'd0;
  logic        bus_ack_i = 1'b0;
`ifdef BEXKAT1_MISALIGN_EXC_EN
  logic        exc_o;
`endif

  mem_access dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .stall_o(stall_o),
    .halt_i(halt_i), .halt_o(halt_o), .reg_write_i(reg_write_i),
    .reg_write_o(reg_write_o), .bank_i(bank_i), .bank_o(bank_o),
    .ir_i(ir_i), .ir_o(ir_o), .alu_i(alu_i), .store_i(store_i),
    .mem_op_i(mem_op_i), .mem_size_i(mem_size_i), .sp_data_o(sp_data_o),
`ifdef BEXKAT1_MISALIGN_EXC_EN
    .exc_o(exc_o),
`endif
    .bus_cyc_o(bus_cyc_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
    .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
    .bus_ack_i(bus_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] sp;
    logic [1:0]  rw;
    logic        halt;
    logic [3:0]  bank;
    logic [63:0] ir;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;
  int tag = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // ---- reference model: byte-addressed big-endian view of a 32-bit word ----
  function automatic logic [3:0] m_sel(input logic [1:0] size, input logic [31:0] a);
    int off = int'(a[1:0]);
    if (size == 2'd0)      return 4'(4'b1000 >> off);
    else if (size == 2'd1) return a[1] ? 4'b0011 : 4'b1100;
    else                   return 4'b1111;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic [31:0] a,
                                         input logic [31:0] d);
    int off = int'(a[1:0]);
    if (size == 2'd0)      return (d >> (8 * (3 - off))) & 32'h0000_00FF;
    else if (size == 2'd1) return a[1] ? (d & 32'h0000_FFFF) : (d >> 16);
    else                   return d;
  endfunction

  function automatic logic [31:0] m_store(input logic [1:0] size, input logic [31:0] s);
    if (size == 2'd0)      return s[7:0] * 32'h0101_0101;
    else if (size == 2'd1) return s[15:0] * 32'h0001_0001;
    else                   return s;
  endfunction

  function automatic bit m_misaligned(input logic [1:0] size, input logic [31:0] a);
`ifdef BEXKAT1_MISALIGN_EXC_EN
    if (size == 2'd0)      return 1'b0;
    else if (size == 2'd1) return a % 2 != 0;
    else                   return a % 4 != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one instruction and act as bus slave until the stage accepts it.
  task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rdata,
                       input int ack_delay, input int ack_stall, input int pre_stall,
                       output int cycles);
    bit   is_mem = (op == 2'd1) || (op == 2'd2);
    bit   exp_exc = is_mem && m_misaligned(size, addr);
    bit   seen = 0, acked = 0, done = 0;
    int   waited = 0, pre_left = pre_stall, hold_left = 0;
    exp_t e;
    tag++;
    ir_i        = {32'(tag), 32'($urandom)};
    reg_write_i = 2'($urandom);
    halt_i      = 1'($urandom);
    bank_i      = 4'($urandom);
    alu_i = addr; store_i = sdata; mem_op_i = op; mem_size_i = size;
    e.sp   = (op == 2'd1) ? m_load(size, addr, rdata) : addr;
    e.rw   = reg_write_i; e.halt = halt_i; e.bank = bank_i; e.ir = ir_i;
    if (!exp_exc) exp_q.push_back(e);
    cycles = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk_i);
      bus_ack_i = 1'b0;
      if (pre_left > 0)       begin stall_i = 1'b1; pre_left--;  end
      else if (hold_left > 0) begin stall_i = 1'b1; hold_left--; end
      else                    stall_i = 1'b0;
      #1;
      if (bus_cyc_o && !acked) begin
        if (!seen) begin
          seen = 1;
          chk("bus_adr", bus_adr_o, {addr[31:2], 2'b00});
          chk("bus_sel", bus_sel_o, m_sel(size, addr));
          chk("bus_we", bus_we_o, op == 2'd2);
          if (op == 2'd2) chk("bus_dat_o", bus_dat_o, m_store(size, sdata));
        end else if (waited == ack_delay) begin
          bus_ack_i = 1'b1; bus_dat_i = rdata; acked = 1;
          if (ack_stall > 0) begin stall_i = 1'b1; hold_left = ack_stall - 1; end
          #1;
        end else waited++;
      end
      if (!stall_o) begin
        cycles = c + 1;
        @(posedge clk_i); #1;
        bus_ack_i = 1'b0;
        done = 1;
      end
    end
    chk("issue_done", done, 1'b1);
    chk("bus_cycle_issued", seen, is_mem && !exp_exc);
  endtask

  // Scoreboard monitor: each new non-bubble instruction word is one result.
  initial begin
    logic [63:0] last_ir;
    exp_t e;
    last_ir = 64'd0;
    forever begin
      @(negedge clk_i);
      if (rst_i) last_ir = 64'd0;
      else if (ir_o != 64'd0 && ir_o !== last_ir) begin
        last_ir = ir_o;
        if (exp_q.size() == 0) chk("unexpected_result", ir_o, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("sp_data", sp_data_o, e.sp);
          chk("reg_write", reg_write_o, e.rw);
          chk("halt", halt_o, e.halt);
          chk("bank", bank_o, e.bank);
          chk("ir", ir_o, e.ir);
        end
      end
    end
  end

  initial begin
    int cyc;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_sp", sp_data_o, 32'd0);
    chk("rst_ir", ir_o, 64'd0);
    chk("rst_rw", reg_write_o, 2'd0);
    chk("rst_halt", halt_o, 1'b0);
    chk("rst_bank", bank_o, 4'd0);
    chk("rst_cyc", bus_cyc_o, 1'b0);
`ifdef BEXKAT1_MISALIGN_EXC_EN
    chk("rst_exc", exc_o, 1'b0);
`endif
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;

    // ALU pass-through, no stall
    issue(2'd0, 2'd2, 32'h0000_1234, 32'd0, 32'd0, 0, 0, 0, cyc);
    chk("alu_no_stall", cyc, 1);
    // word load 0x100, three bubbles then data
    issue(2'd1, 2'd2, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 2, 0, 0, cyc);
    chk("word_load_cycles", cyc, 4);
    // byte store to offset 3
    issue(2'd2, 2'd0, 32'h0000_0203, 32'h0000_00AB, 32'd0, 0, 0, 0, cyc);
    // half load with write-back stalled at ack (HOLD path)
    issue(2'd1, 2'd1, 32'h0000_0002, 32'd0, 32'h1122_3344, 0, 2, 0, cyc);
    chk("half_hold_cycles", cyc, 4);

    // reset in the middle of a bus cycle
    tag++;
    ir_i = {32'(tag), 32'h0}; alu_i = 32'h0000_0100; mem_op_i = 2'd1; mem_size_i = 2'd2;
    stall_i = 1'b0;
    @(negedge clk_i); #1;
    chk("rst_mid_cyc_before", bus_cyc_o, 1'b1);
    @(posedge clk_i); #1;
    rst_i = 1'b1; #1;
    chk("rst_mid_cyc_drop", bus_cyc_o, 1'b0);
    chk("rst_mid_ir", ir_o, 64'd0);
    mem_op_i = 2'd0; stall_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    bus_ack_i = 1'b1; bus_dat_i = 32'hCAFE_F00D;
    @(posedge clk_i); #1;
    bus_ack_i = 1'b0;
    chk("late_ack_cyc", bus_cyc_o, 1'b0);
    chk("late_ack_sp", sp_data_o, 32'd0);
    stall_i = 1'b0;
    issue(2'd0, 2'd0, 32'h0000_5A5A, 32'd0, 32'd0, 0, 0, 0, cyc);
    chk("after_rst_alu_cycles", cyc, 1);

`ifdef BEXKAT1_MISALIGN_EXC_EN
    issue(2'd1, 2'd2, 32'h0000_0101, 32'd0, 32'h1234_5678, 0, 0, 0, cyc);
    chk("misalign_exc", exc_o, 1'b1);
    chk("misalign_bubble", ir_o, 64'd0);
    issue(2'd0, 2'd2, 32'h0000_0777, 32'd0, 32'd0, 0, 0, 0, cyc);
    chk("misalign_exc_cleared", exc_o, 1'b0);
`endif

    for (int i = 0; i < 150; i++) begin
      logic [1:0]  op   = 2'($urandom);
      logic [1:0]  size = 2'($urandom_range(0, 3));
      logic [31:0] a    = $urandom;
`ifdef BEXKAT1_MISALIGN_EXC_EN
      if (size == 2'd1) a[0] = 1'b0;
      else if (size != 2'd0) a[1:0] = 2'b00;
`endif
      issue(op, size, a, $urandom, $urandom, $urandom_range(0, 3),
            $urandom_range(0, 2), $urandom_range(0, 2), cyc);
    end

    repeat (3) @(posedge clk_i);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
